raster_stamp_packer: RTL

RASTER_STAMP_PACKER -- requirements
Module: raster_stamp_packer

---
 rtl/raster_stamp_packer.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/raster_stamp_packer.sv
// Packs rasterizer stamps into NUM_LANES-wide batches and ends each frame with a sticky done batch.
// Optional performance counters are built only when RASTER_PACKER_PERF_EN is defined.
module raster_stamp_packer #(
    parameter int NUM_LANES = 4,
    parameter int STAMP_W   = 96
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [STAMP_W-1:0]           in_stamp,
    input  logic                         in_nostamp,
    input  logic                         in_eof,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [NUM_LANES*STAMP_W-1:0] out_stamps,
    output logic [NUM_LANES-1:0]         out_mask,
    output logic                         out_done,
    input  logic                         out_ready,
    output logic [31:0]                  perf_batches,
    output logic [31:0]                  perf_stalls
);
    localparam int            CW       = $clog2(NUM_LANES + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(NUM_LANES);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                       state_r;
    state_t                       state_next_s;
    logic [CW-1:0]                cnt_r;
    logic [CW-1:0]                cnt_next_s;
    logic                         sealed_r;
    logic                         done_pending_r;
    logic [NUM_LANES*STAMP_W-1:0] lanes_r;
    logic                         out_valid_r;
    logic                         out_done_r;
    logic [NUM_LANES-1:0]         out_mask_r;
    logic [NUM_LANES*STAMP_W-1:0] out_stamps_r;

    logic                         in_ready_s;
    logic                         acc_s;
    logic                         stamp_acc_s;
    logic                         eof_acc_s;
    logic                         out_fire_s;
    logic                         out_free_s;
    logic                         load_data_s;
    logic                         load_done_s;
    logic                         seal_set_s;
    logic [NUM_LANES-1:0]         fill_mask_s;
    logic [NUM_LANES*STAMP_W-1:0] fill_stamps_s;

    // Handshake qualifiers and output-register load decisions.
    always_comb begin
        in_ready_s  = !sealed_r && !done_pending_r;
        acc_s       = in_valid && in_ready_s;
        stamp_acc_s = acc_s && !in_nostamp;
        eof_acc_s   = acc_s && in_eof;
        out_fire_s  = out_valid_r && out_ready;
        out_free_s  = !out_valid_r || out_ready;
        load_data_s = sealed_r && out_free_s;
        load_done_s = done_pending_r && !sealed_r && out_free_s;
        if (stamp_acc_s) begin
            cnt_next_s = cnt_r + CW'(1'b1);
        end else begin
            cnt_next_s = cnt_r;
        end
        seal_set_s = (stamp_acc_s && (cnt_next_s == CNT_FULL)) ||
                     (eof_acc_s && (cnt_next_s != {CW{1'b0}}));
    end

    // Batch image: filled lanes pass through, unfilled lanes read as zero.
    always_comb begin
        fill_mask_s   = {NUM_LANES{1'b0}};
        fill_stamps_s = {(NUM_LANES*STAMP_W){1'b0}};
        for (int i = 0; i < NUM_LANES; i++) begin
            fill_mask_s[i] = (CW'(i) < cnt_r);
            if (fill_mask_s[i]) begin
                fill_stamps_s[i*STAMP_W +: STAMP_W] = lanes_r[i*STAMP_W +: STAMP_W];
            end else begin
                fill_stamps_s[i*STAMP_W +: STAMP_W] = {STAMP_W{1'b0}};
            end
        end
    end

    // Next-state logic for the FILL / FLUSH / DONE controller.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_FILL: begin
                if (seal_set_s || eof_acc_s) begin
                    state_next_s = ST_FLUSH;
                end else begin
                    state_next_s = ST_FILL;
                end
            end
            ST_FLUSH: begin
                if (load_done_s) begin
                    state_next_s = ST_DONE;
                end else if (load_data_s && !done_pending_r) begin
                    state_next_s = ST_FILL;
                end else begin
                    state_next_s = ST_FLUSH;
                end
            end
            ST_DONE: begin
                if (acc_s && (seal_set_s || eof_acc_s)) begin
                    state_next_s = ST_FLUSH;
                end else if (acc_s) begin
                    state_next_s = ST_FILL;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: state_next_s = ST_FILL;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_FILL;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Lane storage, fill count and seal/done bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lanes_r        <= {(NUM_LANES*STAMP_W){1'b0}};
            cnt_r          <= {CW{1'b0}};
            sealed_r       <= 1'b0;
            done_pending_r <= 1'b0;
        end else begin
            if (stamp_acc_s) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (cnt_r == CW'(i)) begin
                        lanes_r[i*STAMP_W +: STAMP_W] <= in_stamp;
                    end
                end
            end
            if (load_data_s) begin
                cnt_r    <= {CW{1'b0}};
                sealed_r <= 1'b0;
            end else begin
                cnt_r <= cnt_next_s;
                if (seal_set_s) begin
                    sealed_r <= 1'b1;
                end
            end
            if (eof_acc_s) begin
                done_pending_r <= 1'b1;
            end else if (load_done_s) begin
                done_pending_r <= 1'b0;
            end
        end
    end

    // Output register; the done batch is re-offered after every fire until new input arrives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_r  <= 1'b0;
            out_done_r   <= 1'b0;
            out_mask_r   <= {NUM_LANES{1'b0}};
            out_stamps_r <= {(NUM_LANES*STAMP_W){1'b0}};
        end else if (load_data_s) begin
            out_valid_r  <= 1'b1;
            out_done_r   <= 1'b0;
            out_mask_r   <= fill_mask_s;
            out_stamps_r <= fill_stamps_s;
        end else if (load_done_s) begin
            out_valid_r  <= 1'b1;
            out_done_r   <= 1'b1;
            out_mask_r   <= {NUM_LANES{1'b0}};
            out_stamps_r <= {(NUM_LANES*STAMP_W){1'b0}};
        end else if ((state_r == ST_DONE) && acc_s) begin
            out_valid_r <= 1'b0;
            out_done_r  <= 1'b0;
        end else if (out_fire_s && (state_r != ST_DONE)) begin
            out_valid_r <= 1'b0;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign out_done   = out_done_r;
    assign out_mask   = out_mask_r;
    assign out_stamps = out_stamps_r;

`ifdef RASTER_PACKER_PERF_EN
    logic [31:0] perf_batches_r;
    logic [31:0] perf_stalls_r;

    // Data-batch fires and backpressure cycles, both wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_batches_r <= 32'd0;
            perf_stalls_r  <= 32'd0;
        end else begin
            if (out_fire_s && !out_done_r) begin
                perf_batches_r <= perf_batches_r + 32'd1;
            end
            if (out_valid_r && !out_ready) begin
                perf_stalls_r <= perf_stalls_r + 32'd1;
            end
        end
    end

    assign perf_batches = perf_batches_r;
    assign perf_stalls  = perf_stalls_r;
`else
    assign perf_batches = 32'd0;
    assign perf_stalls  = 32'd0;
`endif

endmodule
